// File: rtl/seg7_scan_driver.sv
// Time-multiplexed common-anode 7-segment scanner with frame-aligned
// double buffering, leading-zero blanking and a one-cycle ghost guard.
module seg7_scan_driver #(
  parameter int NUM_DIGITS    = 4,
  parameter int REFRESH_DIV   = 100000,
  parameter bit BLANK_LEADING = 1'b1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [4*NUM_DIGITS-1:0] bcd_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    load,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_done
);

  localparam int PW = $clog2(REFRESH_DIV);
  localparam int IW = $clog2(NUM_DIGITS);
  localparam logic [PW-1:0] PMAX = PW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0] IMAX = IW'(NUM_DIGITS - 1);

  logic [PW-1:0]           presc_q, presc_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic                    guard_q, guard_d;
  logic [4*NUM_DIGITS-1:0] disp_q, disp_d;
  logic [NUM_DIGITS-1:0]   disp_dp_q, disp_dp_d;
  logic [4*NUM_DIGITS-1:0] pend_q, pend_d;
  logic [NUM_DIGITS-1:0]   pend_dp_q, pend_dp_d;
  logic                    pv_q, pv_d;
  logic [6:0]              seg_q, seg_d;
  logic                    dp_q, dp_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;
  logic                    fd_q, fd_d;

  logic                    tick;
  logic                    wrap;
  logic [3:0]              dig [NUM_DIGITS];
  logic [NUM_DIGITS-1:0]   blank;

  function automatic logic [6:0] decode(input logic [3:0] v);
    logic [6:0] s;
    unique case (v)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h10;
      default: s = 7'h3F;
    endcase
    return s;
  endfunction

  assign tick = (presc_q == PMAX);
  assign wrap = tick && (idx_q == IMAX);

  always_comb begin
    for (int k = 0; k < NUM_DIGITS; k++) begin
      dig[k] = disp_q[4*k +: 4];
    end
  end

  // A digit blanks only if it and everything above it is zero.
  always_comb begin : blank_mask
    logic zr;
    zr    = 1'b1;
    blank = '0;
    for (int k = NUM_DIGITS - 1; k > 0; k--) begin
      zr       = zr && (dig[k] == 4'd0);
      blank[k] = BLANK_LEADING && zr;
    end
  end

  always_comb begin
    presc_d   = tick ? '0 : presc_q + 1'b1;
    idx_d     = idx_q;
    guard_d   = 1'b0;
    disp_d    = disp_q;
    disp_dp_d = disp_dp_q;
    pend_d    = pend_q;
    pend_dp_d = pend_dp_q;
    pv_d      = pv_q;
    if (tick) begin
      idx_d   = (idx_q == IMAX) ? '0 : idx_q + 1'b1;
      guard_d = 1'b1;
    end
    if (wrap && pv_q) begin
      disp_d    = pend_q;
      disp_dp_d = pend_dp_q;
      pv_d      = 1'b0;
    end
    // A load coinciding with the wrap stays pending for the next frame.
    if (load) begin
      pend_d    = bcd_in;
      pend_dp_d = dp_in;
      pv_d      = 1'b1;
    end
  end

  always_comb begin
    seg_d = 7'h7F;
    dp_d  = 1'b1;
    an_d  = '1;
    fd_d  = wrap;
    if (!guard_q) begin
      an_d[idx_q] = 1'b0;
      seg_d = blank[idx_q] ? 7'h7F : decode(dig[idx_q]);
      dp_d  = ~disp_dp_q[idx_q];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      presc_q   <= '0;
      idx_q     <= '0;
      guard_q   <= 1'b0;
      disp_q    <= '0;
      disp_dp_q <= '0;
      pend_q    <= '0;
      pend_dp_q <= '0;
      pv_q      <= 1'b0;
      seg_q     <= 7'h7F;
      dp_q      <= 1'b1;
      an_q      <= '1;
      fd_q      <= 1'b0;
    end else begin
      presc_q   <= presc_d;
      idx_q     <= idx_d;
      guard_q   <= guard_d;
      disp_q    <= disp_d;
      disp_dp_q <= disp_dp_d;
      pend_q    <= pend_d;
      pend_dp_q <= pend_dp_d;
      pv_q      <= pv_d;
      seg_q     <= seg_d;
      dp_q      <= dp_d;
      an_q      <= an_d;
      fd_q      <= fd_d;
    end
  end

  assign seg        = seg_q;
  assign dp         = dp_q;
  assign an         = an_q;
  assign frame_done = fd_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver (4 digits, 4-cycle slots) with a
// pending-value queue feeding a per-cycle expected-output model.
module tb_seg7_scan_driver;

  localparam int ND = 4;
  localparam int RD = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] bcd_in = '0;
  logic [3:0]  dp_in = '0;
  logic        load = 1'b0;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;
  logic        frame_done;

  int total = 0;
  int bad = 0;
  int n = 0;
  logic [15:0] disp_b = '0;
  logic [3:0]  disp_d = '0;
  logic [19:0] pq[$];

  seg7_scan_driver #(
    .NUM_DIGITS(ND),
    .REFRESH_DIV(RD),
    .BLANK_LEADING(1'b1)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bcd_in(bcd_in),
    .dp_in(dp_in),
    .load(load),
    .seg(seg),
    .dp(dp),
    .an(an),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] dec(input logic [3:0] v);
    case (v)
      4'd0: return 7'h40;
      4'd1: return 7'h79;
      4'd2: return 7'h24;
      4'd3: return 7'h30;
      4'd4: return 7'h19;
      4'd5: return 7'h12;
      4'd6: return 7'h02;
      4'd7: return 7'h78;
      4'd8: return 7'h00;
      4'd9: return 7'h10;
      default: return 7'h3F;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] o,
                     input logic [31:0] e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s n=%0d observed=%h expected=%h", tag, n, o, e);
    end
  endtask

  task automatic chk_blank(input string tag);
    chk({tag, "_seg"}, 32'(seg), 32'h7F);
    chk({tag, "_an"}, 32'(an), 32'hF);
    chk({tag, "_dp"}, 32'(dp), 32'h1);
    chk({tag, "_fd"}, 32'(frame_done), 32'h0);
  endtask

  task automatic step(input logic ld, input logic [15:0] b,
                      input logic [3:0] d);
    logic [6:0] es;
    logic [3:0] ea;
    logic       ed;
    logic       ef;
    logic       zr;
    logic [3:0] dg;
    int m;
    int k;
    bcd_in = b;
    dp_in  = d;
    load   = ld;
    @(posedge clk);
    n++;
    m  = n - 1;
    es = 7'h7F;
    ea = 4'hF;
    ed = 1'b1;
    if (!(m >= RD && (m % RD) == 0)) begin
      k     = (m / RD) % ND;
      ea[k] = 1'b0;
      dg    = disp_b[4*k +: 4];
      zr    = (k > 0);
      for (int j = k; j < ND; j++) begin
        if (disp_b[4*j +: 4] != 4'd0) zr = 1'b0;
      end
      es = zr ? 7'h7F : dec(dg);
      ed = ~disp_d[k];
    end
    ef = ((n % 16) == 0);
    if (ef && pq.size() > 0) begin
      {disp_b, disp_d} = pq.pop_front();
    end
    if (ld) begin
      if (pq.size() > 0) pq[0] = {b, d};
      else pq.push_back({b, d});
    end
    #1;
    load = 1'b0;
    chk("seg", 32'(seg), 32'(es));
    chk("an", 32'(an), 32'(ea));
    chk("dp", 32'(dp), 32'(ed));
    chk("frame_done", 32'(frame_done), 32'(ef));
  endtask

  task automatic run(input int cyc);
    for (int i = 0; i < cyc; i++) step(1'b0, 16'h0, 4'h0);
  endtask

  task automatic release_reset();
    @(negedge clk);
    reset  = 1'b1;
    n      = 0;
    disp_b = '0;
    disp_d = '0;
    pq.delete();
  endtask

  initial begin
    #12;
    chk_blank("rst_hold");
    release_reset();
    run(20);

    step(1'b1, 16'h1234, 4'h0);
    run(40);

    step(1'b1, 16'h0070, 4'h0);
    run(36);

    step(1'b1, 16'h00A0, 4'b0100);
    run(36);

    run(2);
    step(1'b1, 16'h1111, 4'h0);
    while (((n + 1) % 16) != 0) step(1'b0, 16'h0, 4'h0);
    step(1'b1, 16'h2222, 4'h1);
    run(40);

    while ((n % 16) != 5) step(1'b0, 16'h0, 4'h0);
    step(1'b1, 16'h9876, 4'hF);
    run(3);
    #2;
    reset = 1'b0;
    #1;
    chk_blank("rst_async");
    repeat (3) @(posedge clk);
    #1;
    chk_blank("rst_held");
    release_reset();
    run(36);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

endmodule
